// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/ack data-memory port, steers byte lanes,
// extends loaded bytes and registers the MEM/WB result. Stalls upstream while an access is open.
module mem_access_stage #(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_Mem,
    input  logic [31:0] ALU_ans_Mem,
    input  logic [31:0] busB_Mem,
    input  logic [4:0]  Reg_Target_Mem,
    input  logic        RegWr_Mem,
    input  logic        MemToReg_Mem,
    input  logic        MemWr_Mem,
    input  logic        WrByte_Mem,
    input  logic [1:0]  LoadByte_Mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        wb_RegWr,
    output logic [4:0]  wb_Reg_Target,
    output logic [31:0] wb_data,
    output logic        mem_err,
    output logic        state_dbg
);

    // Handshake: dm_req rises on the issue edge and every dm_* output stays frozen until
    // the edge that samples a one-cycle dm_ack (or the timeout edge); dm_rdata is only
    // meaningful in the dm_ack cycle, and an ack seen outside WAIT is dropped.
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] lat_alu;
    logic        lat_store;
    logic        lat_regwr;
    logic [1:0]  lat_lt;
    logic [4:0]  lat_rd;

    logic        mem_op;
    logic        word_op;
    logic        misaligned;
    logic        issue;
    logic [31:0] lane_word;
    logic [31:0] load_data;

    always_comb begin
        mem_op = valid_Mem & (MemWr_Mem | MemToReg_Mem);
        if (MemWr_Mem)
            word_op = ~WrByte_Mem;
        else
            word_op = ~((LoadByte_Mem == 2'b01) || (LoadByte_Mem == 2'b10));
        misaligned = mem_op & word_op & (ALU_ans_Mem[1:0] != 2'b00);
        issue      = (state == S_IDLE) & mem_op & ~misaligned;
        stall_out  = issue | ((state == S_WAIT) & ~dm_ack & (cnt != TIMEOUT));
    end

    // Little-endian lane select: shift the addressed byte down to bits 7:0.
    always_comb begin
        lane_word = dm_rdata >> {lat_alu[1:0], 3'b000};
        case (lat_lt)
            2'b01:   load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            2'b10:   load_data = {24'd0, lane_word[7:0]};
            default: load_data = dm_rdata;
        endcase
    end

    assign state_dbg = (state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            lat_alu       <= 32'd0;
            lat_store     <= 1'b0;
            lat_regwr     <= 1'b0;
            lat_lt        <= 2'b00;
            lat_rd        <= 5'd0;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= 32'd0;
            dm_be         <= 4'd0;
            dm_wdata      <= 32'd0;
            wb_valid      <= 1'b0;
            wb_RegWr      <= 1'b0;
            wb_Reg_Target <= 5'd0;
            wb_data       <= 32'd0;
            mem_err       <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state     <= S_WAIT;
                        cnt       <= 4'd0;
                        lat_alu   <= ALU_ans_Mem;
                        lat_store <= MemWr_Mem;
                        lat_regwr <= RegWr_Mem;
                        lat_lt    <= LoadByte_Mem;
                        lat_rd    <= Reg_Target_Mem;
                        dm_req    <= 1'b1;
                        dm_we     <= MemWr_Mem;
                        dm_addr   <= {ALU_ans_Mem[31:2], 2'b00};
                        if (MemWr_Mem && WrByte_Mem) begin
                            dm_be    <= 4'b0001 << ALU_ans_Mem[1:0];
                            dm_wdata <= {4{busB_Mem[7:0]}};
                        end else begin
                            dm_be    <= 4'hF;
                            dm_wdata <= MemWr_Mem ? busB_Mem : 32'd0;
                        end
                        wb_valid <= 1'b0;
                        wb_RegWr <= 1'b0;
                    end else begin
                        wb_valid      <= valid_Mem;
                        wb_RegWr      <= valid_Mem & RegWr_Mem & ~mem_op;
                        wb_Reg_Target <= Reg_Target_Mem;
                        wb_data       <= ALU_ans_Mem;
                        mem_err       <= misaligned;
                    end
                end
                S_WAIT: begin
                    if (dm_ack) begin
                        state         <= S_IDLE;
                        dm_req        <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_RegWr      <= ~lat_store & lat_regwr;
                        wb_Reg_Target <= lat_rd;
                        wb_data       <= lat_store ? lat_alu : load_data;
                    end else if (cnt == TIMEOUT) begin
                        state         <= S_IDLE;
                        dm_req        <= 1'b0;
                        mem_err       <= 1'b1;
                        wb_valid      <= 1'b1;
                        wb_RegWr      <= 1'b0;
                        wb_Reg_Target <= lat_rd;
                        wb_data       <= lat_alu;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus a random back-to-back mix,
// with WB results checked against an expected queue.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_Mem;
    logic [31:0] ALU_ans_Mem;
    logic [31:0] busB_Mem;
    logic [4:0]  Reg_Target_Mem;
    logic        RegWr_Mem;
    logic        MemToReg_Mem;
    logic        MemWr_Mem;
    logic        WrByte_Mem;
    logic [1:0]  LoadByte_Mem;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall_out;
    logic        wb_valid;
    logic        wb_RegWr;
    logic [4:0]  wb_Reg_Target;
    logic [31:0] wb_data;
    logic        mem_err;
    logic        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {check_rd_and_data, regwr, rd, data, mem_err}
    logic [39:0] exp_q[$];

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_Mem(valid_Mem), .ALU_ans_Mem(ALU_ans_Mem),
        .busB_Mem(busB_Mem), .Reg_Target_Mem(Reg_Target_Mem), .RegWr_Mem(RegWr_Mem),
        .MemToReg_Mem(MemToReg_Mem), .MemWr_Mem(MemWr_Mem), .WrByte_Mem(WrByte_Mem),
        .LoadByte_Mem(LoadByte_Mem), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall_out(stall_out), .wb_valid(wb_valid), .wb_RegWr(wb_RegWr),
        .wb_Reg_Target(wb_Reg_Target), .wb_data(wb_data), .mem_err(mem_err),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // WB monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wb_unexpected got wb_data=%h rd=%0d want no WB", wb_data, wb_Reg_Target);
                    n_fail++;
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    if (wb_RegWr !== e[38]) begin
                        $display("FAIL wb_RegWr got %b want %b", wb_RegWr, e[38]);
                        n_fail++;
                    end
                    n_checks++;
                    if (mem_err !== e[0]) begin
                        $display("FAIL wb_mem_err got %b want %b", mem_err, e[0]);
                        n_fail++;
                    end
                    if (e[39]) begin
                        n_checks++;
                        if (wb_Reg_Target !== e[37:33] || wb_data !== e[32:1]) begin
                            $display("FAIL wb_data got rd=%0d data=%h want rd=%0d data=%h",
                                     wb_Reg_Target, wb_data, e[37:33], e[32:1]);
                            n_fail++;
                        end
                    end
                end
            end else begin
                n_checks++;
                if (mem_err !== 1'b0) begin
                    $display("FAIL mem_err_no_wb got %b want 0", mem_err);
                    n_fail++;
                end
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [1:0] lt, input logic [1:0] lo,
                                               input logic [31:0] rd);
        logic [7:0] b;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (lt)
            2'b01:   return {{24{b[7]}}, b};
            2'b10:   return {24'h0, b};
            default: return rd;
        endcase
    endfunction

    // Driver tasks
    task automatic idle_in();
        valid_Mem = 1'b0; ALU_ans_Mem = 32'd0; busB_Mem = 32'd0; Reg_Target_Mem = 5'd0;
        RegWr_Mem = 1'b0; MemToReg_Mem = 1'b0; MemWr_Mem = 1'b0; WrByte_Mem = 1'b0;
        LoadByte_Mem = 2'b00; dm_ack = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s got %h want %h", name, got, want);
            n_fail++;
        end
    endtask

    // Called at a negedge, returns at a negedge with inputs idle.
    task automatic run_alu(input logic [31:0] a, input logic [4:0] rd, input logic rw);
        valid_Mem = 1'b1; ALU_ans_Mem = a; Reg_Target_Mem = rd; RegWr_Mem = rw;
        MemToReg_Mem = 1'b0; MemWr_Mem = 1'b0;
        exp_q.push_back({1'b1, rw, rd, a, 1'b0});
        #1 chk("alu_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        idle_in();
        chk("alu_stall_after", {31'd0, stall_out}, 32'd0);
    endtask

    task automatic run_mem(input logic st, input logic byte_op, input logic [1:0] lt,
                           input logic [31:0] addr, input logic [31:0] bus,
                           input logic [31:0] rdata, input int n_wait, input logic [4:0] rd,
                           input logic rw, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_wb);
        valid_Mem = 1'b1; ALU_ans_Mem = addr; busB_Mem = bus; Reg_Target_Mem = rd;
        RegWr_Mem = rw; MemToReg_Mem = ~st; MemWr_Mem = st; WrByte_Mem = byte_op;
        LoadByte_Mem = lt;
        if (st) exp_q.push_back({1'b0, 1'b0, 5'd0, 32'd0, 1'b0});
        else    exp_q.push_back({1'b1, rw, rd, exp_wb, 1'b0});
        #1 chk("issue_stall", {31'd0, stall_out}, 32'd1);
        @(negedge clk);
        chk("dm_req", {31'd0, dm_req}, 32'd1);
        chk("dm_we", {31'd0, dm_we}, {31'd0, st});
        chk("dm_addr", dm_addr, {addr[31:2], 2'b00});
        chk("dm_be", {28'd0, dm_be}, {28'd0, exp_be});
        if (st) chk("dm_wdata", dm_wdata, exp_wd);
        for (int i = 0; i < n_wait; i++) begin
            chk("wait_stall", {31'd0, stall_out}, 32'd1);
            chk("wait_req", {31'd0, dm_req}, 32'd1);
            @(negedge clk);
        end
        dm_ack = 1'b1; dm_rdata = rdata;
        #1 chk("ack_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        idle_in();
        dm_rdata = $urandom();
        chk("req_drop", {31'd0, dm_req}, 32'd0);
    endtask

    // Scenarios
    task automatic test_reset();
        idle_in(); dm_rdata = 32'd0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_wb", {25'd0, wb_valid, wb_RegWr, wb_Reg_Target}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err_state", {30'd0, mem_err, state_dbg}, 32'd0);
        chk("rst_dm", {dm_be, dm_we} ^ {dm_addr[4:0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        run_alu(32'h1234, 5'd5, 1'b1);
        run_alu(32'hCAFE_0001, 5'd31, 1'b0);
    endtask

    task automatic test_store();
        run_mem(1'b1, 1'b0, 2'b00, 32'h100, 32'hDEADBEEF, 32'd0, 3, 5'd1, 1'b1,
                4'hF, 32'hDEADBEEF, 32'd0);
        run_mem(1'b1, 1'b1, 2'b00, 32'h103, 32'h000000A5, 32'd0, 1, 5'd2, 1'b0,
                4'b1000, 32'hA5A5A5A5, 32'd0);
    endtask

    task automatic test_load_ext();
        run_mem(1'b0, 1'b0, 2'b01, 32'h102, 32'd0, 32'h0080FF00, 0, 5'd7, 1'b1,
                4'hF, 32'd0, 32'hFFFFFF80);
        run_mem(1'b0, 1'b0, 2'b10, 32'h102, 32'd0, 32'h0080FF00, 2, 5'd8, 1'b1,
                4'hF, 32'd0, 32'h00000080);
        run_mem(1'b0, 1'b0, 2'b00, 32'h200, 32'd0, 32'h89ABCDEF, 1, 5'd9, 1'b1,
                4'hF, 32'd0, 32'h89ABCDEF);
    endtask

    task automatic test_misaligned();
        valid_Mem = 1'b1; ALU_ans_Mem = 32'h101; MemToReg_Mem = 1'b1; LoadByte_Mem = 2'b00;
        RegWr_Mem = 1'b1; Reg_Target_Mem = 5'd3;
        exp_q.push_back({1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
        #1 chk("mis_lw_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        idle_in();
        valid_Mem = 1'b1; ALU_ans_Mem = 32'h102; MemWr_Mem = 1'b1; busB_Mem = 32'h55;
        exp_q.push_back({1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
        chk("mis_lw_req", {31'd0, dm_req}, 32'd0);
        #1 chk("mis_sw_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        idle_in();
        chk("mis_sw_req", {30'd0, dm_req, state_dbg}, 32'd0);
    endtask

    task automatic test_timeout();
        valid_Mem = 1'b1; ALU_ans_Mem = 32'h300; MemToReg_Mem = 1'b1; RegWr_Mem = 1'b1;
        Reg_Target_Mem = 5'd4;
        exp_q.push_back({1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk("to_stall", {31'd0, stall_out}, 32'd1);
            chk("to_req", {31'd0, dm_req}, 32'd1);
            @(negedge clk);
        end
        chk("to_last_stall", {31'd0, stall_out}, 32'd0);
        chk("to_last_req", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        idle_in();
        chk("to_req_drop", {30'd0, dm_req, state_dbg}, 32'd0);
    endtask

    task automatic test_reset_in_wait();
        valid_Mem = 1'b1; ALU_ans_Mem = 32'h200; MemWr_Mem = 1'b1; busB_Mem = 32'h1;
        @(negedge clk);
        chk("rw_req", {31'd0, dm_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        idle_in();
        #1 chk("rw_req_async", {31'd0, dm_req}, 32'd0);
        chk("rw_stall", {31'd0, stall_out}, 32'd0);
        chk("rw_wb", {30'd0, wb_valid, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        #1 chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        dm_ack = 1'b0;
        chk("late_ack_wb", {30'd0, wb_valid, dm_req}, 32'd0);
        @(negedge clk);
        chk("late_ack_wb2", {30'd0, wb_valid, mem_err}, 32'd0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 24; k++) begin
            int          kind;
            logic [31:0] a, b, r;
            logic [4:0]  rd;
            logic [1:0]  lt;
            logic        bo;
            logic [3:0]  be;
            kind = $urandom_range(0, 2);
            a = $urandom(); b = $urandom(); r = $urandom(); rd = 5'($urandom_range(0, 31));
            if (kind == 0) begin
                run_alu(a, rd, 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                bo = 1'($urandom_range(0, 1));
                if (!bo) a[1:0] = 2'b00;
                case (a[1:0])
                    2'd0:    be = 4'b0001;
                    2'd1:    be = 4'b0010;
                    2'd2:    be = 4'b0100;
                    default: be = 4'b1000;
                endcase
                if (!bo) be = 4'hF;
                run_mem(1'b1, bo, 2'b00, a, b, r, $urandom_range(0, 3), rd, 1'b1, be,
                        bo ? {4{b[7:0]}} : b, 32'd0);
            end else begin
                lt = 2'($urandom_range(0, 3));
                if (!(lt == 2'b01 || lt == 2'b10)) a[1:0] = 2'b00;
                run_mem(1'b0, 1'b0, lt, a, b, r, $urandom_range(0, 3), rd, 1'b1, 4'hF,
                        32'd0, model_load(lt, a[1:0], r));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_ext();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
